// File: rtl/memory_access.sv
// Memory-access pipeline stage: issues loads/stores over a req/ack data-memory
// handshake, aligns load data and registers writeback controls.
module memory_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2E,
  input  logic        write_regE,
  input  logic [2:0]  info_loadE,
  input  logic [1:0]  info_storeE,
  input  logic [4:0]  dstreg_addrE,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] wb_data,
  output logic        wb_write_reg,
  output logic [4:0]  wb_dstreg_addr,
  output logic        misalign,
  output logic        bus_fault
);

  localparam int unsigned CNT_W = 16;

  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LH  = 3'd2;
  localparam logic [2:0] LD_LW  = 3'd3;
  localparam logic [2:0] LD_LBU = 3'd4;
  localparam logic [2:0] LD_LHU = 3'd5;

  localparam logic [1:0] ST_SB = 2'd1;
  localparam logic [1:0] ST_SH = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_WORD = 2'd3;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [2:0]        ld_op, ld_op_nxt;
  logic [1:0]        off, off_nxt;
  logic              is_load, is_load_nxt;
  logic              wr_lat, wr_lat_nxt;
  logic [4:0]        dst_lat, dst_lat_nxt;

  logic              dmem_req_nxt, dmem_we_nxt;
  logic [31:0]       dmem_addr_nxt, dmem_wdata_nxt;
  logic [3:0]        dmem_wstrb_nxt;
  logic [31:0]       wb_data_nxt;
  logic              wb_write_reg_nxt;
  logic [4:0]        wb_dstreg_addr_nxt;
  logic              misalign_nxt, bus_fault_nxt;

  logic              ld_c, st_c, aligned_c;
  logic [1:0]        size_c;
  logic [3:0]        wstrb_c;
  logic [31:0]       wdata_c;
  logic [31:0]       shifted_c, load_val_c;

  assign stall = (state == BUSY);

  // Decode of the incoming instruction; a valid load wins over a store.
  always_comb begin
    ld_c      = (info_loadE >= LD_LB) && (info_loadE <= LD_LHU);
    st_c      = !ld_c && (info_storeE != 2'd0);
    size_c    = 2'd0;
    if (ld_c) begin
      unique case (info_loadE)
        LD_LB, LD_LBU: size_c = SZ_BYTE;
        LD_LH, LD_LHU: size_c = SZ_HALF;
        default:       size_c = SZ_WORD;
      endcase
    end else if (st_c) begin
      unique case (info_storeE)
        ST_SB:   size_c = SZ_BYTE;
        ST_SH:   size_c = SZ_HALF;
        default: size_c = SZ_WORD;
      endcase
    end
    unique case (size_c)
      SZ_HALF: aligned_c = !alu_result[0];
      SZ_WORD: aligned_c = (alu_result[1:0] == 2'b00);
      default: aligned_c = 1'b1;
    endcase
  end

  // Store lane steering; loads drive no strobes.
  always_comb begin
    wstrb_c = 4'b0000;
    wdata_c = 32'd0;
    if (st_c) begin
      unique case (size_c)
        SZ_BYTE: begin
          wstrb_c = 4'b0001 << alu_result[1:0];
          wdata_c = {4{rs2E[7:0]}};
        end
        SZ_HALF: begin
          wstrb_c = alu_result[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{rs2E[15:0]}};
        end
        default: begin
          wstrb_c = 4'b1111;
          wdata_c = rs2E;
        end
      endcase
    end
  end

  // Load data alignment and extension from the latched offset.
  always_comb begin
    shifted_c = dmem_rdata >> {off, 3'b000};
    unique case (ld_op)
      LD_LB:   load_val_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      LD_LH:   load_val_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      LD_LBU:  load_val_c = {24'd0, shifted_c[7:0]};
      LD_LHU:  load_val_c = {16'd0, shifted_c[15:0]};
      default: load_val_c = dmem_rdata;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt          = state;
    cnt_nxt            = cnt;
    ld_op_nxt          = ld_op;
    off_nxt            = off;
    is_load_nxt        = is_load;
    wr_lat_nxt         = wr_lat;
    dst_lat_nxt        = dst_lat;
    dmem_req_nxt       = dmem_req;
    dmem_we_nxt        = dmem_we;
    dmem_addr_nxt      = dmem_addr;
    dmem_wdata_nxt     = dmem_wdata;
    dmem_wstrb_nxt     = dmem_wstrb;
    wb_data_nxt        = wb_data;
    wb_write_reg_nxt   = wb_write_reg;
    wb_dstreg_addr_nxt = wb_dstreg_addr;
    misalign_nxt       = 1'b0;
    bus_fault_nxt      = 1'b0;

    unique case (state)
      IDLE: begin
        if (!ld_c && !st_c) begin
          wb_data_nxt        = alu_result;
          wb_write_reg_nxt   = write_regE && (dstreg_addrE != 5'd0);
          wb_dstreg_addr_nxt = dstreg_addrE;
        end else if (!aligned_c) begin
          misalign_nxt     = 1'b1;
          wb_write_reg_nxt = 1'b0;
        end else begin
          ld_op_nxt        = ld_c ? info_loadE : 3'd0;
          off_nxt          = alu_result[1:0];
          is_load_nxt      = ld_c;
          wr_lat_nxt       = write_regE;
          dst_lat_nxt      = dstreg_addrE;
          dmem_req_nxt     = 1'b1;
          dmem_we_nxt      = st_c;
          dmem_addr_nxt    = {alu_result[31:2], 2'b00};
          dmem_wdata_nxt   = wdata_c;
          dmem_wstrb_nxt   = wstrb_c;
          wb_write_reg_nxt = 1'b0;
          cnt_nxt          = '0;
          state_nxt        = BUSY;
        end
      end
      BUSY: begin
        wb_write_reg_nxt = 1'b0;
        if (dmem_ack) begin
          dmem_req_nxt = 1'b0;
          state_nxt    = IDLE;
          if (is_load) begin
            wb_data_nxt        = load_val_c;
            wb_write_reg_nxt   = wr_lat && (dst_lat != 5'd0);
            wb_dstreg_addr_nxt = dst_lat;
          end
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          dmem_req_nxt  = 1'b0;
          bus_fault_nxt = 1'b1;
          state_nxt     = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      ld_op          <= 3'd0;
      off            <= 2'd0;
      is_load        <= 1'b0;
      wr_lat         <= 1'b0;
      dst_lat        <= 5'd0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= 32'd0;
      dmem_wdata     <= 32'd0;
      dmem_wstrb     <= 4'd0;
      wb_data        <= 32'd0;
      wb_write_reg   <= 1'b0;
      wb_dstreg_addr <= 5'd0;
      misalign       <= 1'b0;
      bus_fault      <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      ld_op          <= ld_op_nxt;
      off            <= off_nxt;
      is_load        <= is_load_nxt;
      wr_lat         <= wr_lat_nxt;
      dst_lat        <= dst_lat_nxt;
      dmem_req       <= dmem_req_nxt;
      dmem_we        <= dmem_we_nxt;
      dmem_addr      <= dmem_addr_nxt;
      dmem_wdata     <= dmem_wdata_nxt;
      dmem_wstrb     <= dmem_wstrb_nxt;
      wb_data        <= wb_data_nxt;
      wb_write_reg   <= wb_write_reg_nxt;
      wb_dstreg_addr <= wb_dstreg_addr_nxt;
      misalign       <= misalign_nxt;
      bus_fault      <= bus_fault_nxt;
    end
  end

endmodule
